// File: rtl/bc_mem_arbiter_pkg.sv
// Shared types for the memory arbiter: the requester owner tag and the in-flight read entry.
// Also holds the helper that drops fetch entries on a pipeline flush.
package bc_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } owner_entry_t;

  // A flush drops fetch responses only; load/store entries survive it.
  function automatic owner_entry_t flush_entry(owner_entry_t e, logic flush);
    owner_entry_t r;
    r = e;
    if (flush && (e.owner == OWN_IF)) begin
      r.valid = 1'b0;
    end else begin
      r.valid = e.valid;
    end
    return r;
  endfunction

endpackage

// File: rtl/bc_mem_arbiter_if.sv
// Requester and memory-port signal bundle for bc_mem_arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface bc_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  i_if_req;
  logic [ADDR_WIDTH-1:0] i_if_addr;
  logic                  o_if_gnt;
  logic                  i_if_flush;
  logic                  o_if_rvalid;
  logic [DATA_WIDTH-1:0] o_if_rdata;
  logic                  i_ls_req;
  logic                  i_ls_we;
  logic [ADDR_WIDTH-1:0] i_ls_addr;
  logic [DATA_WIDTH-1:0] i_ls_wdata;
  logic                  o_ls_gnt;
  logic                  o_ls_rvalid;
  logic [DATA_WIDTH-1:0] o_ls_rdata;
  logic                  o_m_ren;
  logic [ADDR_WIDTH-1:0] o_m_raddr;
  logic                  o_m_wen;
  logic                  o_m_wdata_valid;
  logic [ADDR_WIDTH-1:0] o_m_waddr;
  logic [DATA_WIDTH-1:0] o_m_wdata;
  logic                  i_m_rdata_valid;
  logic [DATA_WIDTH-1:0] i_m_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush,
    input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
    input  i_m_rdata_valid, i_m_rdata,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_m_ren, o_m_raddr, o_m_wen, o_m_wdata_valid, o_m_waddr, o_m_wdata
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush,
    output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata,
    output i_m_rdata_valid, i_m_rdata,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_m_ren, o_m_raddr, o_m_wen, o_m_wdata_valid, o_m_waddr, o_m_wdata
  );
endinterface

// File: rtl/bc_mem_arbiter_rsp_tracker.sv
// RD_LAT-deep shift register remembering who issued each in-flight read.
// The head entry lines up with the memory response; fetch entries vanish on flush.
module bc_rsp_tracker
  import bc_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  owner_entry_t i_push,
  input  logic         i_flush,
  output owner_entry_t o_head
);

  owner_entry_t [RD_LAT-1:0] pipe_q;
  owner_entry_t [RD_LAT-1:0] pipe_d;

  // Next stage contents: shift by one, scrubbing fetch entries when flushing.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = flush_entry(i_push, i_flush);
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = flush_entry(pipe_q[i-1], i_flush);
    end
  end

  // Pipeline state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_head = flush_entry(pipe_q[RD_LAT-1], i_flush);

endmodule

// File: rtl/bc_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (read-only) and the LSU.
// LSU has priority; a fetch that has lost MAX_WAIT cycles in a row wins the next one.
module bc_mem_arbiter
  import bc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bc_mem_arbiter_if.slave   bus
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [WCW-1:0] wait_cnt_q;
  logic [WCW-1:0] wait_cnt_d;
  logic           wait_at_max;
  logic           if_gnt;
  logic           ls_gnt;
  logic           rd_issue;
  logic           rsp_ok;
  owner_entry_t   push_entry;
  owner_entry_t   head_entry;

  assign wait_at_max = (wait_cnt_q == WCW'(MAX_WAIT));

  // Grant decision; everything is held off while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!i_rst) begin
      if_gnt = bus.i_if_req && (!bus.i_ls_req || wait_at_max);
      ls_gnt = bus.i_ls_req && !if_gnt;
    end else begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
    end
  end

  // Starvation counter: counts consecutive cycles a pending fetch is passed over.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (bus.i_if_req && !if_gnt) begin
      if (wait_at_max) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
    end else begin
      wait_cnt_d = {WCW{1'b0}};
    end
  end

  // Wait counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt_q <= {WCW{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign rd_issue         = if_gnt || (ls_gnt && !bus.i_ls_we);
  assign push_entry.valid = rd_issue;
  assign push_entry.owner = if_gnt ? OWN_IF : OWN_LS;

  bc_rsp_tracker #(
    .RD_LAT (RD_LAT)
  ) u_rsp_tracker (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_entry),
    .i_flush (bus.i_if_flush),
    .o_head  (head_entry)
  );

  assign rsp_ok = !i_rst && bus.i_m_rdata_valid && head_entry.valid;

  // Memory port muxing and response steering.
  always_comb begin
    bus.o_if_gnt        = if_gnt;
    bus.o_ls_gnt        = ls_gnt;
    bus.o_m_ren         = rd_issue;
    bus.o_m_raddr       = {ADDR_WIDTH{1'b0}};
    bus.o_m_wen         = ls_gnt && bus.i_ls_we;
    bus.o_m_wdata_valid = ls_gnt && bus.i_ls_we;
    bus.o_m_waddr       = {ADDR_WIDTH{1'b0}};
    bus.o_m_wdata       = {DATA_WIDTH{1'b0}};
    if (if_gnt) begin
      bus.o_m_raddr = bus.i_if_addr;
    end else if (ls_gnt) begin
      bus.o_m_raddr = bus.i_ls_addr;
    end else begin
      bus.o_m_raddr = {ADDR_WIDTH{1'b0}};
    end
    if (ls_gnt && bus.i_ls_we) begin
      bus.o_m_waddr = bus.i_ls_addr;
      bus.o_m_wdata = bus.i_ls_wdata;
    end else begin
      bus.o_m_waddr = {ADDR_WIDTH{1'b0}};
      bus.o_m_wdata = {DATA_WIDTH{1'b0}};
    end
    bus.o_if_rvalid = rsp_ok && (head_entry.owner == OWN_IF);
    bus.o_ls_rvalid = rsp_ok && (head_entry.owner == OWN_LS);
    bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_m_rdata : {DATA_WIDTH{1'b0}};
    bus.o_ls_rdata  = bus.o_ls_rvalid ? bus.i_m_rdata : {DATA_WIDTH{1'b0}};
  end

endmodule
